// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grants of up to NR_WRITE_PORTS
// requests per cycle onto registered write ports, serializing same-address writes.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NR_REQ         = 4,
  parameter int unsigned NR_WRITE_PORTS = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic [NR_REQ-1:0]                        req_valid_i,
  input  logic [NR_REQ-1:0][4:0]                   req_addr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]        req_data_i,
  output logic [NR_REQ-1:0]                        req_ready_o,
  output logic [NR_WRITE_PORTS-1:0][4:0]           waddr_o,
  output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_o,
  output logic [NR_WRITE_PORTS-1:0]                we_o,
  output logic                                     wb_stall_o
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PTR_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [PTR_W-1:0]                          rr_ptr_q, rr_ptr_d;
  logic [NR_WRITE_PORTS-1:0]                 we_q, we_d;
  logic [NR_WRITE_PORTS-1:0][ADDR_W-1:0]     waddr_q, waddr_d;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NR_REQ-1:0]                         ready_c;
  logic [PTR_W-1:0]                          idx, jdx;
  logic                                      conflict;
  int unsigned                               n_grant;

  // Operand is always below 2*NR_REQ, so one conditional subtract suffices.
  function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned v);
    int unsigned w;
    w = v;
    if (w >= NR_REQ) w = w - NR_REQ;
    return PTR_W'(w);
  endfunction

  always_comb begin
    ready_c  = '0;
    we_d     = '0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rr_ptr_d = rr_ptr_q;
    n_grant  = 0;
    conflict = 1'b0;
    idx      = '0;
    jdx      = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      idx = wrap_idx(32'(rr_ptr_q) + i);
      if (!flush_i && req_valid_i[idx]) begin
        if (req_addr_i[idx] == '0) begin
          ready_c[idx] = 1'b1;
        end else begin
          // Any earlier valid request to the same register blocks this one.
          conflict = 1'b0;
          for (int unsigned j = 0; j < NR_REQ; j++) begin
            if (j < i) begin
              jdx = wrap_idx(32'(rr_ptr_q) + j);
              if (req_valid_i[jdx] && (req_addr_i[jdx] == req_addr_i[idx])) conflict = 1'b1;
            end
          end
          if (!conflict && (n_grant < NR_WRITE_PORTS)) begin
            ready_c[idx] = 1'b1;
            for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
              if (p == n_grant) begin
                we_d[p]    = 1'b1;
                waddr_d[p] = req_addr_i[idx];
                wdata_d[p] = req_data_i[idx];
              end
            end
            n_grant  = n_grant + 1;
            rr_ptr_d = wrap_idx(32'(idx) + 1);
          end
        end
      end
    end
    if (flush_i) rr_ptr_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      we_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign req_ready_o = ready_c;
  assign wb_stall_o  = |(req_valid_i & ~ready_c);
  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with NR_REQ=4, NR_WRITE_PORTS=2.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned NP = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   flush_i;
  logic [NR-1:0]          req_valid_i;
  logic [NR-1:0][4:0]     req_addr_i;
  logic [NR-1:0][DW-1:0]  req_data_i;
  logic [NR-1:0]          req_ready_o;
  logic [NP-1:0][4:0]     waddr_o;
  logic [NP-1:0][DW-1:0]  wdata_o;
  logic [NP-1:0]          we_o;
  logic                   wb_stall_o;

  logic [DW-1:0] rf [32];
  int checks   = 0;
  int failures = 0;
  logic [NR-1:0] rdy;
  logic          stall;
  logic          auto_clear;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .NR_REQ(NR), .NR_WRITE_PORTS(NP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .we_o(we_o), .wb_stall_o(wb_stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Register-file model committed from the write ports.
  always @(posedge clk_i) begin
    for (int p = 0; p < NP; p++) if (we_o[p]) rf[waddr_o[p]] <= wdata_o[p];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [4:0] a, input logic [DW-1:0] d);
    req_valid_i[r] = 1'b1;
    req_addr_i[r]  = a;
    req_data_i[r]  = d;
  endtask

  task automatic set_all4();
    for (int r = 0; r < NR; r++) set_req(r, 5'(r + 1), DW'(32'hA1 + r));
  endtask

  // One cycle: sample combinational outputs mid-cycle, then settle after the edge.
  task automatic tick();
    @(negedge clk_i);
    rdy   = req_ready_o;
    stall = wb_stall_o;
    @(posedge clk_i);
    #1;
    if (auto_clear) req_valid_i = req_valid_i & ~rdy;
  endtask

  int last_grant [NR];
  int max_wait;
  int req2_cycle;

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
    auto_clear = 1'b1; rdy = '0; stall = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    #12;
    check_eq("reset_we", 64'(we_o), 64'h0);
    check_eq("reset_waddr", 64'(waddr_o), 64'h0);
    check_eq("reset_wdata", 64'(wdata_o), 64'h0);
    @(posedge clk_i); #1; rst_ni = 1'b1;

    // Round-robin over four distinct addresses
    set_all4();
    tick();
    check_eq("rr_c0_ready", 64'(rdy), 64'h3);
    check_eq("rr_c0_stall", 64'(stall), 64'h1);
    check_eq("rr_c1_we", 64'(we_o), 64'h3);
    check_eq("rr_c1_waddr", 64'(waddr_o), 64'({5'd2, 5'd1}));
    check_eq("rr_c1_wdata", 64'(wdata_o), {32'hA2, 32'hA1});
    tick();
    check_eq("rr_c1_ready", 64'(rdy), 64'hC);
    check_eq("rr_c2_waddr", 64'(waddr_o), 64'({5'd4, 5'd3}));
    check_eq("rr_c2_wdata", 64'(wdata_o), {32'hA4, 32'hA3});
    tick();
    check_eq("rr_idle_we", 64'(we_o), 64'h0);
    check_eq("rr_idle_hold_waddr", 64'(waddr_o), 64'({5'd4, 5'd3}));

    // Asynchronous reset mid-cycle with both ports active
    set_all4();
    tick();
    check_eq("rst_pre_ready", 64'(rdy), 64'h3);
    check_eq("rst_pre_we", 64'(we_o), 64'h3);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rst_async_we", 64'(we_o), 64'h0);
    check_eq("rst_async_waddr", 64'(waddr_o), 64'h0);
    check_eq("rst_async_wdata", 64'(wdata_o), 64'h0);
    rst_ni = 1'b1;
    set_all4();
    tick();
    check_eq("rst_first_ready", 64'(rdy), 64'h3);
    tick();
    check_eq("rst_second_ready", 64'(rdy), 64'hC);
    tick();

    // Same-address conflict serialized in scan order
    set_req(0, 5'd5, DW'(32'hAA));
    set_req(1, 5'd5, DW'(32'hBB));
    tick();
    check_eq("conf_c0_ready", 64'(rdy), 64'h1);
    check_eq("conf_c0_stall", 64'(stall), 64'h1);
    check_eq("conf_c1_port0", {27'h0, we_o[0], waddr_o[0], wdata_o[0]}, {27'h0, 1'b1, 5'd5, 32'hAA});
    tick();
    check_eq("conf_c1_ready", 64'(rdy), 64'h2);
    check_eq("conf_c2_port0", {27'h0, we_o[0], waddr_o[0], wdata_o[0]}, {27'h0, 1'b1, 5'd5, 32'hBB});
    check_eq("conf_c2_we1", 64'(we_o[1]), 64'h0);
    tick();
    check_eq("conf_rf5", 64'(rf[5]), 64'hBB);

    // Single request on req3 brings the pointer from 2 back to 0
    set_req(3, 5'd12, DW'(32'hCC));
    tick();
    check_eq("wrap_ready", 64'(rdy), 64'h8);

    // Address-0 request accepted without a port
    set_req(0, 5'd7, DW'(32'h77));
    set_req(1, 5'd0, DW'(32'h55));
    set_req(2, 5'd8, DW'(32'h88));
    tick();
    check_eq("x0_ready", 64'(rdy), 64'h7);
    check_eq("x0_stall", 64'(stall), 64'h0);
    check_eq("x0_we", 64'(we_o), 64'h3);
    check_eq("x0_waddr", 64'(waddr_o), 64'({5'd8, 5'd7}));
    check_eq("x0_wdata", 64'(wdata_o), {32'h88, 32'h77});

    // Flush with the pointer at 2 (req1 grant from ptr 3 sets it)
    set_req(1, 5'd1, DW'(32'h11));
    tick();
    check_eq("fl_setup_ready", 64'(rdy), 64'h2);
    set_all4();
    flush_i = 1'b1;
    check_eq("fl_prior_write_kept", 64'({waddr_o[0], we_o}), 64'({5'd1, 2'b01}));
    tick();
    check_eq("fl_ready", 64'(rdy), 64'h0);
    check_eq("fl_stall", 64'(stall), 64'h1);
    check_eq("fl_we", 64'(we_o), 64'h0);
    flush_i = 1'b0;
    tick();
    check_eq("fl_after_ready", 64'(rdy), 64'h3);
    req_valid_i = '0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;

    // Fairness with req0/req1 always valid and req2 arriving alongside
    auto_clear = 1'b0;
    set_req(0, 5'd9, DW'(32'h9));
    set_req(1, 5'd10, DW'(32'hA));
    set_req(2, 5'd11, DW'(32'hB));
    for (int r = 0; r < NR; r++) last_grant[r] = -1;
    max_wait = 0;
    req2_cycle = -1;
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int r = 0; r < 3; r++) begin
        if (rdy[r]) begin
          if (c - last_grant[r] > max_wait) max_wait = c - last_grant[r];
          last_grant[r] = c;
          if (r == 2 && req2_cycle < 0) req2_cycle = c;
        end
      end
      if (req2_cycle >= 0) req_valid_i[2] = 1'b0;
    end
    check_eq("fair_req2_cycle", 64'(req2_cycle), 64'd1);
    check_eq("fair_max_wait_ok", 64'(max_wait <= int'(NR)), 64'h1);
    check_eq("fair_req0_recent", 64'(last_grant[0] >= 4), 64'h1);
    check_eq("fair_req1_recent", 64'(last_grant[1] >= 4), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
